pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and next-PC stage of the single-cycle MIPS CPU, directly upstream of the instruction ROM. It drives the fetch address and selects the next PC from the sequential, branch, jump and register-jump paths. It vectors into the kernel handlers on undefined instructions, misaligned jumps and the external timer interrupt. PC bit 31 is the kernel-mode flag; `pc[30:0]` feeds the ROM address port.

## Interface
- `RESET_VEC`, default 32'h8000_0000: PC value after reset (kernel mode).
- `ILLOP_VEC`, default 32'h8000_0004: handler entry for interrupts and undefined instructions.
- `XADR_VEC`, default 32'h8000_0008: handler entry for a misaligned `jr` target.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
- `branch_taken`  in  1  resolved conditional branch this cycle.
- `branch_imm`  in  16  raw instruction immediate.
- `jump`  in  1  `j`/`jal` this cycle.
- `jump_target`  in  26  instruction target field.
- `jr`  in  1  `jr`/`jalr` this cycle.
- `jr_addr`  in  32  register value for `jr`.
- `illop`  in  1  decoder flags an undefined opcode.
- `irq`  in  1  timer interrupt; asynchronous, level.
- `pc`  out  32  current fetch address.
- `pc_plus4`  out  32  link value for `jal`/`jalr`.
- `kernel`  out  1  equals `pc[31]`.
- `exc_taken`  out  1  combinational; the current instruction is aborted (suppress RegWrite/MemWrite).
- `epc`  out  32  value the datapath writes into $26 when `exc_taken`=1.
- `exc_cause`  out  2  0 none, 1 irq, 2 illop, 3 xadr; qualified by `exc_taken`.

## Operation
- Width rule: all address arithmetic is on bits [30:0] and wraps modulo 2^31. Bit 31 is preserved except on exception entry (set to 1) and `jr` (taken from `jr_addr[31]`).
- `pc_plus4` = {pc[31], pc[30:0]+4}.
- Branch target = {pc[31], pc_plus4[30:0] + (sext(branch_imm)<<2)}.
- Jump target = {pc[31], pc_plus4[30:28], jump_target, 2'b00}.
- IRQ path:
  - `irq` passes through a 2-flop synchronizer; `irq_s` is the second flop.
  - `irq_ok` = `irq_s` & !kernel & !holdoff.
- Holdoff flop:
  - Set on the edge where a `jr` loads a PC with bit31=0 while the current `pc[31]`=1 (kernel→user return).
  - Cleared on the next edge.
  - This guarantees that one user instruction executes before an interrupt is re-taken.
- Next-PC priority (highest first):
  - `illop` → ILLOP_VEC, cause 2. Taken in either mode.
  - `irq_ok` → ILLOP_VEC, cause 1.
  - `jr` with `jr_addr[1:0]`≠0 → XADR_VEC, cause 3.
  - `jr` → `jr_addr`.
  - `jump` → jump target.
  - `branch_taken` → branch target.
  - otherwise → `pc_plus4`.
- `epc`:
  - cause 1: current `pc` (the aborted instruction re-executes on return).
  - causes 2 and 3: `pc_plus4`.
  - Otherwise `epc` = `pc_plus4`; don't-care.
- Control inputs asserted together with a higher-priority event are ignored.

## Timing
- Reset (asynchronous): `pc`=RESET_VEC, `kernel`=1, synchronizer flops=0, holdoff=0, `exc_taken`=0, `exc_cause`=0, `pc_plus4`=32'h8000_0004.
- Reset deasserted mid-operation: the first fetch is RESET_VEC; no pending irq survives reset.
- `pc` changes only at the rising edge. Next-PC selection and the outputs `exc_taken`/`exc_cause`/`epc` are combinational within the cycle.
- IRQ latency: `irq` asserted before edge N is seen as `irq_s` after edge N+1. The vector is loaded at edge N+2, provided the unit is in user mode and holdoff=0.
- `irq` held high while in kernel mode is not taken. It is taken on the first eligible user-mode cycle after holdoff clears.
- `irq` pulse shorter than one cycle: behaviour not guaranteed. The timer holds `irq` until software clears it.

## Test plan
- Reset mid-run at PC 32'h0040_0020 → `pc`=32'h8000_0000 immediately; next edge `pc`=32'h8000_0004 with no controls asserted.
- Sequential run and branch: at `pc`=32'h0040_0010, `branch_taken`=1, `branch_imm`=16'hFFFD → next `pc`=32'h0040_0008. At `pc`=32'h7FFF_FFFC, no control → `pc`=32'h0000_0000 (bit31 stays 0).
- Jump:
  - At `pc`=32'h8000_0000, `jump_target`=26'h010_0004 → next `pc`=32'h8040_0010 (kernel kept).
  - Then `jr`, `jr_addr`=32'h0040_0010 → `pc`=32'h0040_0010, `kernel`=0, holdoff=1.
- IRQ:
  - `irq` high at user `pc`=32'h0040_0100 → two cycles later `exc_taken`=1, `exc_cause`=1, `epc`=current `pc`, next `pc`=32'h8000_0004.
  - `irq` still high in kernel → no further entry.
  - After a `jr` back to user, exactly one user instruction executes, then re-entry occurs.
- Exceptions:
  - `illop` in user or kernel mode at `pc`=P → `exc_cause`=2, `epc`=P+4, next `pc`=32'h8000_0004.
  - `jr_addr`=32'h0040_0012 → `exc_cause`=3, next `pc`=32'h8000_0008.
  - `illop` with `irq_ok` and `jump` asserted together → cause 2.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Fetch-stage bundle between the decoder/datapath and the PC unit.
// Controls flow into the unit; the fetch address and exception status flow out.
interface pc_fetch_if;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_target;
    logic        jr;
    logic [31:0] jr_addr;
    logic        illop;
    logic        irq;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        kernel;
    logic        exc_taken;
    logic [31:0] epc;
    logic [1:0]  exc_cause;

    modport master (
        output branch_taken, branch_imm, jump, jump_target, jr, jr_addr, illop, irq,
        input  pc, pc_plus4, kernel, exc_taken, epc, exc_cause
    );

    modport slave (
        input  branch_taken, branch_imm, jump, jump_target, jr, jr_addr, illop, irq,
        output pc, pc_plus4, kernel, exc_taken, epc, exc_cause
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and next-PC selection for the single-cycle MIPS core.
// PC bit 31 is the kernel flag; address arithmetic wraps within bits [30:0].
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
    parameter logic [31:0] XADR_VEC  = 32'h8000_0008
) (
    input logic       clk,
    input logic       reset,
    pc_fetch_if.slave bus
);

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_IRQ   = 2'd1,
        CAUSE_ILLOP = 2'd2,
        CAUSE_XADR  = 2'd3
    } cause_t;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_addr;
    logic [31:0] epc;
    logic [30:0] branch_off;
    logic        irq_meta;
    logic        irq_s;
    logic        holdoff;
    logic        holdoff_d;
    logic        irq_ok;
    cause_t      cause;

    assign pc_plus4      = {pc_q[31], pc_q[30:0] + 31'd4};
    assign branch_off    = {{13{bus.branch_imm[15]}}, bus.branch_imm, 2'b00};
    assign branch_target = {pc_q[31], pc_plus4[30:0] + branch_off};
    assign jump_addr     = {pc_q[31], pc_plus4[30:28], bus.jump_target, 2'b00};

    // Holdoff masks the interrupt for the first user instruction after a kernel return.
    assign irq_ok = irq_s & ~pc_q[31] & ~holdoff;

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        pc_d      = pc_plus4;
        cause     = CAUSE_NONE;
        epc       = pc_plus4;
        holdoff_d = 1'b0;
        if (bus.illop) begin
            pc_d  = ILLOP_VEC;
            cause = CAUSE_ILLOP;
        end else if (irq_ok) begin
            pc_d  = ILLOP_VEC;
            cause = CAUSE_IRQ;
            epc   = pc_q;
        end else if (bus.jr && (bus.jr_addr[1:0] != 2'b00)) begin
            pc_d  = XADR_VEC;
            cause = CAUSE_XADR;
        end else if (bus.jr) begin
            pc_d      = bus.jr_addr;
            holdoff_d = pc_q[31] & ~bus.jr_addr[31];
        end else if (bus.jump) begin
            pc_d = jump_addr;
        end else if (bus.branch_taken) begin
            pc_d = branch_target;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values, which the synchronizer chain depends on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_VEC;
            irq_meta <= 1'b0;
            irq_s    <= 1'b0;
            holdoff  <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            irq_meta <= bus.irq;
            irq_s    <= irq_meta;
            holdoff  <= holdoff_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_plus4  = pc_plus4;
    assign bus.kernel    = pc_q[31];
    assign bus.exc_taken = (cause != CAUSE_NONE);
    assign bus.exc_cause = cause;
    assign bus.epc       = epc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a chained vector table from reset plus
// hand-written sequences for interrupt latency, holdoff and asynchronous reset.
module tb_pc_fetch_unit;

    logic clk;
    logic reset;
    pc_fetch_if bus ();

    pc_fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        br;
        logic [15:0] imm;
        logic        jmp;
        logic [25:0] tgt;
        logic        jr;
        logic [31:0] jra;
        logic        ill;
        logic [31:0] pc;
        logic        exc;
        logic [1:0]  cause;
        logic [31:0] epc;
        logic [31:0] nxt;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs[NVEC];

    int n_vec;
    int n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic br, input logic [15:0] imm, input logic jmp,
                         input logic [25:0] tgt, input logic jr, input logic [31:0] jra,
                         input logic ill);
        bus.branch_taken = br;
        bus.branch_imm   = imm;
        bus.jump         = jmp;
        bus.jump_target  = tgt;
        bus.jr           = jr;
        bus.jr_addr      = jra;
        bus.illop        = ill;
    endtask

    task automatic idle();
        apply(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_exc(input string name, input logic exc, input logic [1:0] cause,
                             input logic [31:0] epc);
        check({name, ".exc_taken"}, {31'd0, bus.exc_taken}, {31'd0, exc});
        check({name, ".exc_cause"}, {30'd0, bus.exc_cause}, {30'd0, cause});
        if (exc) check({name, ".epc"}, bus.epc, epc);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;

        // Chained from reset: each row's pc is the previous row's next pc.
        //            br imm       jmp tgt         jr jra           ill pc            exc cause epc           nxt
        vecs[0]  = '{0, 16'h0000, 1, 26'h0100004, 0, 32'h0,        0, 32'h8000_0000, 0, 2'd0, 32'h8000_0004, 32'h8040_0010};
        vecs[1]  = '{0, 16'h0000, 0, 26'h0,       1, 32'h0040_0010,0, 32'h8040_0010, 0, 2'd0, 32'h8040_0014, 32'h0040_0010};
        vecs[2]  = '{1, 16'hFFFD, 0, 26'h0,       0, 32'h0,        0, 32'h0040_0010, 0, 2'd0, 32'h0040_0014, 32'h0040_0008};
        vecs[3]  = '{0, 16'h0000, 0, 26'h0,       0, 32'h0,        0, 32'h0040_0008, 0, 2'd0, 32'h0040_000C, 32'h0040_000C};
        vecs[4]  = '{1, 16'h0004, 0, 26'h0,       0, 32'h0,        0, 32'h0040_000C, 0, 2'd0, 32'h0040_0010, 32'h0040_0020};
        vecs[5]  = '{0, 16'h0000, 1, 26'h0000123, 0, 32'h0,        1, 32'h0040_0020, 1, 2'd2, 32'h0040_0024, 32'h8000_0004};
        vecs[6]  = '{0, 16'h0000, 0, 26'h0,       0, 32'h0,        1, 32'h8000_0004, 1, 2'd2, 32'h8000_0008, 32'h8000_0004};
        vecs[7]  = '{0, 16'h0000, 0, 26'h0,       1, 32'h0040_0012,0, 32'h8000_0004, 1, 2'd3, 32'h8000_0008, 32'h8000_0008};
        vecs[8]  = '{0, 16'h0000, 0, 26'h0,       1, 32'h7FFF_FFF8,0, 32'h8000_0008, 0, 2'd0, 32'h8000_000C, 32'h7FFF_FFF8};
        vecs[9]  = '{0, 16'h0000, 0, 26'h0,       0, 32'h0,        0, 32'h7FFF_FFF8, 0, 2'd0, 32'h7FFF_FFFC, 32'h7FFF_FFFC};
        vecs[10] = '{0, 16'h0000, 0, 26'h0,       0, 32'h0,        0, 32'h7FFF_FFFC, 0, 2'd0, 32'h0000_0000, 32'h0000_0000};
        vecs[11] = '{1, 16'h0001, 1, 26'h3FFFFFF, 0, 32'h0,        0, 32'h0000_0000, 0, 2'd0, 32'h0000_0004, 32'h0FFF_FFFC};
        vecs[12] = '{1, 16'h7FFF, 0, 26'h0,       0, 32'h0,        0, 32'h0FFF_FFFC, 0, 2'd0, 32'h1000_0000, 32'h1001_FFFC};
        vecs[13] = '{1, 16'h0010, 1, 26'h0000040, 1, 32'h8000_0100,0, 32'h1001_FFFC, 0, 2'd0, 32'h1002_0000, 32'h8000_0100};
        vecs[14] = '{0, 16'h0000, 0, 26'h0,       1, 32'h8000_0101,0, 32'h8000_0100, 1, 2'd3, 32'h8000_0104, 32'h8000_0008};

        reset = 1'b1;
        bus.irq = 1'b0;
        idle();
        #3;
        check("reset.pc", bus.pc, 32'h8000_0000);
        check("reset.pc_plus4", bus.pc_plus4, 32'h8000_0004);
        check("reset.kernel", {31'd0, bus.kernel}, 32'd1);
        check_exc("reset", 1'b0, 2'd0, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i].br, vecs[i].imm, vecs[i].jmp, vecs[i].tgt,
                  vecs[i].jr, vecs[i].jra, vecs[i].ill);
            #1;
            check($sformatf("vec%0d.pc", i), bus.pc, vecs[i].pc);
            check($sformatf("vec%0d.kernel", i), {31'd0, bus.kernel}, {31'd0, vecs[i].pc[31]});
            check_exc($sformatf("vec%0d", i), vecs[i].exc, vecs[i].cause, vecs[i].epc);
            step();
            check($sformatf("vec%0d.next_pc", i), bus.pc, vecs[i].nxt);
        end

        // IRQ latency from user mode; holdoff from the preceding jr lasts one cycle.
        apply(1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0040_0100, 1'b0);
        step();
        check("irq.user_pc", bus.pc, 32'h0040_0100);
        check("irq.user_kernel", {31'd0, bus.kernel}, 32'd0);
        idle();
        bus.irq = 1'b1;
        #1;
        check_exc("irq.cycle0", 1'b0, 2'd0, 32'h0);
        step();
        check("irq.cycle1_pc", bus.pc, 32'h0040_0104);
        check_exc("irq.cycle1", 1'b0, 2'd0, 32'h0);
        step();
        check("irq.cycle2_pc", bus.pc, 32'h0040_0108);
        check_exc("irq.cycle2", 1'b1, 2'd1, 32'h0040_0108);
        step();
        check("irq.vector", bus.pc, 32'h8000_0004);
        check_exc("irq.kernel0", 1'b0, 2'd0, 32'h0);
        step();
        check("irq.kernel1_pc", bus.pc, 32'h8000_0008);
        check_exc("irq.kernel1", 1'b0, 2'd0, 32'h0);

        // Return to user with irq still high: one instruction, then re-entry.
        apply(1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0040_0200, 1'b0);
        #1;
        check_exc("ret.jr_cycle", 1'b0, 2'd0, 32'h0);
        step();
        idle();
        #1;
        check("ret.user_pc", bus.pc, 32'h0040_0200);
        check_exc("ret.holdoff", 1'b0, 2'd0, 32'h0);
        step();
        check("ret.second_pc", bus.pc, 32'h0040_0204);
        check_exc("ret.reentry", 1'b1, 2'd1, 32'h0040_0204);
        step();
        check("ret.vector", bus.pc, 32'h8000_0004);

        // illop beats a live irq_ok and a jump.
        apply(1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0040_0300, 1'b0);
        step();
        idle();
        step();
        check("prio.pc", bus.pc, 32'h0040_0304);
        apply(1'b0, 16'h0, 1'b1, 26'h0000123, 1'b0, 32'h0, 1'b1);
        #1;
        check_exc("prio.illop", 1'b1, 2'd2, 32'h0040_0308);
        step();
        check("prio.vector", bus.pc, 32'h8000_0004);
        idle();
        bus.irq = 1'b0;
        step();
        step();

        // Asynchronous reset mid-cycle from a user PC.
        apply(1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0040_0020, 1'b0);
        step();
        idle();
        check("rst.before_pc", bus.pc, 32'h0040_0020);
        #2;
        reset = 1'b1;
        #1;
        check("rst.async_pc", bus.pc, 32'h8000_0000);
        check("rst.async_kernel", {31'd0, bus.kernel}, 32'd1);
        check_exc("rst.async", 1'b0, 2'd0, 32'h0);
        #2;
        reset = 1'b0;
        step();
        check("rst.first_fetch", bus.pc, 32'h8000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
